// File: rtl/exp7_source.sv
// Full-adder cell: combinational s/cout, a registered copy, and an LSB-first serial word adder.
// Latency: s/cout 0, s_q/cout_q 1 cycle, sum_word WIDTH consuming edges; en/serial_mode stall only, no backpressure.
module exp7_source #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    output logic             s,
    output logic             cout,
    input  logic             en,
    input  logic             serial_mode,
    input  logic             start,
    output logic             s_q,
    output logic             cout_q,
    output logic             busy,
    output logic [WIDTH-1:0] sum_word,
    output logic             carry_word,
    output logic             word_valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;
    logic          cr;
    logic          consume;
    logic          cin_sel;
    logic          bit_s;
    logic          bit_c;

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

    // The serial engine reuses the same cell; start selects the word carry-in instead of cr.
    assign consume = en & serial_mode;
    assign cin_sel = start ? cin : cr;
    assign bit_s   = a ^ b ^ cin_sel;
    assign bit_c   = (a & b) | (a & cin_sel) | (b & cin_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q        <= 1'b0;
            cout_q     <= 1'b0;
            busy       <= 1'b0;
            sum_word   <= '0;
            carry_word <= 1'b0;
            word_valid <= 1'b0;
            cr         <= 1'b0;
            cnt        <= '0;
        end else begin
            word_valid <= 1'b0;
            if (en) begin
                s_q    <= s;
                cout_q <= cout;
            end
            if (consume) begin
                if (start) begin
                    sum_word <= {{(WIDTH-1){1'b0}}, bit_s};
                    cr       <= bit_c;
                    cnt      <= CW'(1);
                    busy     <= 1'b1;
                end else if (busy) begin
                    sum_word[cnt] <= bit_s;
                    cr            <= bit_c;
                    if (cnt == LAST) begin
                        carry_word <= bit_c;
                        busy       <= 1'b0;
                        word_valid <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_exp7_source.sv
// Bench for exp7_source at WIDTH=4: directed adder scenarios plus random serial traffic vs an integer-sum model.
`timescale 1ns/1ps
module tb_exp7_source;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         a = 1'b0, b = 1'b0, cin = 1'b0;
    logic         en = 1'b0, serial_mode = 1'b0, start = 1'b0;
    logic         s, cout, s_q, cout_q, busy, carry_word, word_valid;
    logic [W-1:0] sum_word;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state, expressed as whole-word arithmetic
    int    m_n;
    int    m_pa, m_pb, m_cin;
    bit    m_active;
    int    m_sum, m_carry;
    bit    m_wv;
    bit    m_sq, m_cq;

    exp7_source #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
        .s(s), .cout(cout), .en(en), .serial_mode(serial_mode), .start(start),
        .s_q(s_q), .cout_q(cout_q), .busy(busy), .sum_word(sum_word),
        .carry_word(carry_word), .word_valid(word_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_pa = 0; m_pb = 0; m_cin = 0; m_active = 0;
        m_sum = 0; m_carry = 0; m_wv = 0; m_sq = 0; m_cq = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".s_q"}, 32'(s_q), 32'(m_sq));
        chk({tag, ".cout_q"}, 32'(cout_q), 32'(m_cq));
        chk({tag, ".busy"}, 32'(busy), 32'(m_active));
        chk({tag, ".sum_word"}, 32'(sum_word), 32'(m_sum));
        chk({tag, ".carry_word"}, 32'(carry_word), 32'(m_carry));
        chk({tag, ".word_valid"}, 32'(word_valid), 32'(m_wv));
    endtask

    // One clock: drive at edge+1, check comb at edge+2, then check registered state at next edge+1
    task automatic step(input logic ia, ib, ic, ien, imode, istart, input string tag);
        int tot;
        a = ia; b = ib; cin = ic; en = ien; serial_mode = imode; start = istart;
        #1;
        chk({tag, ".s"}, 32'(s), 32'((int'(ia) + int'(ib) + int'(ic)) % 2));
        chk({tag, ".cout"}, 32'(cout), 32'((int'(ia) + int'(ib) + int'(ic)) / 2));
        @(posedge clk); #1;
        m_wv = 0;
        if (ien) begin
            m_sq = ((int'(ia) + int'(ib) + int'(ic)) % 2) != 0;
            m_cq = ((int'(ia) + int'(ib) + int'(ic)) / 2) != 0;
        end
        if (ien && imode) begin
            if (istart) begin
                m_n = 0; m_pa = 0; m_pb = 0; m_cin = int'(ic); m_active = 1;
            end
            if (m_active) begin
                m_pa = m_pa + (int'(ia) << m_n);
                m_pb = m_pb + (int'(ib) << m_n);
                m_n++;
                tot = m_pa + m_pb + m_cin;
                m_sum = tot % (1 << m_n);
                if (m_n == W) begin
                    m_carry = tot >> W;
                    m_active = 0;
                    m_wv = 1;
                end
            end
        end
        check_all(tag);
    endtask

    task automatic feed_word(input int av, input int bv, input logic ci,
                             input int stall_after, input int stall_len, input string tag);
        for (int k = 0; k < W; k++) begin
            step(av[k], bv[k], (k == 0) ? ci : 1'b0, 1'b1, 1'b1, (k == 0), tag);
            if (k == stall_after) begin
                for (int j = 0; j < stall_len; j++)
                    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, {tag, ".stall"});
            end
        end
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".sum_word"}, 32'(sum_word), 32'd0);
        chk({tag, ".word_valid"}, 32'(word_valid), 32'd0);
        chk({tag, ".s_q"}, 32'(s_q), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [2:0] v;
    logic [2:0] cv [5] = '{3'b000, 3'b101, 3'b010, 3'b101, 3'b110};
    logic       cs [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       cc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Combinational vectors, 100 ns apart, with registers disabled
        for (int i = 0; i < 5; i++) begin
            {a, b, cin} = cv[i];
            #1;
            chk("comb_vec.s", 32'(s), 32'(cs[i]));
            chk("comb_vec.cout", 32'(cout), 32'(cc[i]));
            #99;
        end
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a, b, cin} = v;
            #1;
            chk("comb_sweep.s", 32'(s), 32'(int'(v[0]) ^ int'(v[1]) ^ int'(v[2])));
            chk("comb_sweep.cout", 32'(cout), 32'((int'(v[0]) + int'(v[1]) + int'(v[2])) >= 2));
            #9;
        end
        @(posedge clk); #1;
        check_all("after_comb");

        // Registered path
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "reg_load");
        chk("reg_load.s_q_const", 32'(s_q), 32'd1);
        chk("reg_load.cout_q_const", 32'(cout_q), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reg_hold");
        chk("reg_hold.s_q_const", 32'(s_q), 32'd1);

        // 5 + 6, cin=0
        feed_word(5, 6, 1'b0, -1, 0, "w5p6");
        chk("w5p6.sum_const", 32'(sum_word), 32'b1011);
        chk("w5p6.carry_const", 32'(carry_word), 32'd0);
        chk("w5p6.vld_const", 32'(word_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "w5p6.idle");
        chk("w5p6.vld_drop", 32'(word_valid), 32'd0);

        // 9 + 8 + 1 with a 3-cycle stall between bits 1 and 2
        feed_word(9, 8, 1'b1, 1, 3, "w9p8");
        chk("w9p8.sum_const", 32'(sum_word), 32'b0010);
        chk("w9p8.carry_const", 32'(carry_word), 32'd1);
        // word_valid drops while stalled
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "w9p8.stalled");

        // Restart at bit 2: first word discarded
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "restart.b0");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "restart.b1");
        feed_word(7, 3, 1'b0, -1, 0, "restart.new");
        chk("restart.sum_const", 32'(sum_word), 32'd10);

        // Reset mid-word
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "rst.b0");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "rst.b1");
        async_reset("rst_mid");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "rst.after");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "rst.after2");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 5) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exp7_source.md
Name: exp7_source

Overview:
- Single-bit full-adder cell with a combinational path, a registered copy of that path, and a bit-serial word adder built around the same cell.
- The combinational sum/carry outputs s/cout are the primary function.
- The registered and serial outputs let the cell act as a pipelined or LSB-first serial adder inside larger arithmetic datapaths.

Parameters:
WIDTH, 8, word length in bits for the serial adder (legal range 2..32).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
a  input  1  addend bit
b  input  1  addend bit
cin  input  1  carry-in bit
s  output  1  combinational sum, a^b^cin
cout  output  1  combinational carry, majority(a,b,cin)
en  input  1  clock enable for all registered logic
serial_mode  input  1  1 = serial engine consumes a/b each enabled cycle
start  input  1  begin a new serial word; the current a/b is bit 0 and cin is the word carry-in
s_q  output  1  registered s
cout_q  output  1  registered cout
busy  output  1  serial word in progress
sum_word  output  WIDTH  serial result, LSB first assembled
carry_word  output  1  final carry of the serial word
word_valid  output  1  one-cycle pulse when sum_word/carry_word are updated

Behaviour:
Reset:
- rst_n low asynchronously clears s_q, cout_q, busy, sum_word, carry_word, word_valid, the internal carry register and the bit counter.
- s/cout stay combinational during reset.

Combinational path:
- s = a xor b xor cin.
- cout = (a&b)|(a&cin)|(b&cin).
- Zero latency; independent of clk, en, rst_n and mode.

Registered path:
- On a rising clk with en=1: s_q<=s, cout_q<=cout. Latency 1 cycle.
- en=0 holds both registers.

Serial engine (state: IDLE/RUN via busy, bit counter 0..WIDTH-1, carry register cr):
- A bit is consumed on a rising clk only when en=1 and serial_mode=1.
- start=1 on a consuming edge (from any state, including mid-word):
  - bit 0 = a^b^cin; cr<=majority(a,b,cin).
  - Bit 0 is written to sum_word[0]; all other sum_word bits are cleared.
  - Counter set to 1; busy<=1.
- busy=1 and start=0 on a consuming edge:
  - Bit k = a^b^cr is written to sum_word[k]; cr<=majority(a,b,cr); counter increments.
- Consuming bit WIDTH-1:
  - carry_word<=final carry; busy<=0.
  - word_valid is high for exactly the next cycle.
- Stalls: en=0 or serial_mode=0 holds all serial state. A word may span stalls.
- Idle inputs: consuming edges with busy=0 and start=0 are ignored. sum_word and carry_word hold the last result.
- word_valid deasserts after one cycle even if the engine is stalled. A start on the cycle word_valid is high is legal.
- WIDTH=1 is not supported.
- Reset mid-word aborts the word: no word_valid pulse, and sum_word reads 0.

Test Plan:
- Combinational vectors, 100 ns apart:
  - (a,b,cin)=(0,0,0) -> s=0, cout=0
  - (1,0,1) -> s=0, cout=1
  - (0,1,0) -> s=1, cout=0
  - (1,0,1) -> s=0, cout=1
  - (1,1,0) -> s=0, cout=1
  - Then sweep all 8 combos against the majority/xor model.
- Registered path: en=1, apply (1,1,1) -> s_q=1, cout_q=1 one edge later. Drop en, change inputs -> s_q/cout_q hold.
- Serial, WIDTH=4, cin=0: feed 5 (a=0101) and 6 (b=0110) LSB first with start on bit 0 -> after 4 consuming edges, word_valid=1 for one cycle, sum_word=1011, carry_word=0.
- Serial with carry-in, WIDTH=4: 9+8 with cin=1 -> sum_word=0010, carry_word=1. Insert en=0 stalls between bits 1 and 2 -> same result, word_valid delayed by the stall length.
- Restart and reset:
  - start asserted at bit 2 of a word -> that word is discarded and the new word completes after WIDTH consuming edges from the restart.
  - rst_n pulsed low mid-word -> busy=0 and sum_word=0 immediately (asynchronously), with no word_valid pulse.
